// File: rtl/registers_bank_mp_if.sv
// Register-bank port bundle: pipeline read/write, debug read and clear-sweep control.
// master = ID/WB/debug side driving requests, slave = the register bank.
interface registers_bank_mp_if #(
  parameter int unsigned NB_DATA  = 32,
  parameter int unsigned NB_ADDR  = 5,
  parameter int unsigned NUM_READ = 2
);
  logic                         i_enable;
  logic                         i_reg_write;
  logic [NB_ADDR-1:0]           i_write_reg;
  logic [NB_DATA-1:0]           i_write_data;
  logic                         i_jr_jalr;
  logic [NUM_READ*NB_ADDR-1:0]  i_read_addr;
  logic [NUM_READ*NB_DATA-1:0]  o_read_data;
  logic                         i_debug_read_en;
  logic [NB_ADDR-1:0]           i_debug_addr;
  logic [NB_DATA-1:0]           o_debug_data;
  logic                         o_debug_valid;
  logic                         i_clear_req;
  logic                         o_busy;

  modport master (
    output i_enable, i_reg_write, i_write_reg, i_write_data, i_jr_jalr, i_read_addr,
           i_debug_read_en, i_debug_addr, i_clear_req,
    input  o_read_data, o_debug_data, o_debug_valid, o_busy
  );

  modport slave (
    input  i_enable, i_reg_write, i_write_reg, i_write_data, i_jr_jalr, i_read_addr,
           i_debug_read_en, i_debug_addr, i_clear_req,
    output o_read_data, o_debug_data, o_debug_valid, o_busy
  );
endinterface

// File: rtl/registers_bank_mp.sv
// Multi-read-port register file with write-through bypass, hardwired r0, link-register
// override on port 0, debug read port and a post-reset / on-request clear sweep.
module registers_bank_mp #(
  parameter int unsigned NB_DATA     = 32,
  parameter int unsigned NB_ADDR     = 5,
  parameter int unsigned BANK_DEPTH  = 32,
  parameter int unsigned NUM_READ    = 2,
  parameter int unsigned LINK_REG    = 31,
  parameter int unsigned ZERO_REG_EN = 1,
  parameter int unsigned BYPASS_EN   = 1
) (
  input logic                i_clock,
  input logic                i_reset_n,
  registers_bank_mp_if.slave bus
);

  typedef enum logic {ST_CLEAR, ST_IDLE} state_e;

  // Storage has no reset; the sweep zeroes it instead.
  logic [NB_DATA-1:0]          regs_q [BANK_DEPTH];
  state_e                      state_q;
  logic [NB_ADDR-1:0]          cnt_q;
  logic [NUM_READ*NB_DATA-1:0] rdata_q, rdata_d;
  logic [NB_DATA-1:0]          dbg_data_q, dbg_data_d;
  logic                        dbg_valid_q;
  logic                        busy_q;
  logic [NB_ADDR-1:0]          rd_addr [NUM_READ];
  logic                        wr_en_c;

  always_comb begin
    wr_en_c = (state_q == ST_IDLE) && bus.i_enable && bus.i_reg_write
           && (32'(bus.i_write_reg) < BANK_DEPTH)
           && !((ZERO_REG_EN != 0) && (bus.i_write_reg == '0));
  end

  // Per-port read mux: r0 and out-of-range first, then bypass, then array.
  always_comb begin
    rdata_d = rdata_q;
    for (int p = 0; p < NUM_READ; p++) begin
      if ((p == 0) && bus.i_jr_jalr) rd_addr[p] = NB_ADDR'(LINK_REG);
      else                           rd_addr[p] = bus.i_read_addr[p*NB_ADDR +: NB_ADDR];

      if (((ZERO_REG_EN != 0) && (rd_addr[p] == '0)) || (32'(rd_addr[p]) >= BANK_DEPTH))
        rdata_d[p*NB_DATA +: NB_DATA] = '0;
      else if ((BYPASS_EN != 0) && bus.i_reg_write && (bus.i_write_reg == rd_addr[p]))
        rdata_d[p*NB_DATA +: NB_DATA] = bus.i_write_data;
      else
        rdata_d[p*NB_DATA +: NB_DATA] = regs_q[rd_addr[p]];
    end
  end

  always_comb begin
    dbg_data_d = '0;
    if (!(((ZERO_REG_EN != 0) && (bus.i_debug_addr == '0)) || (32'(bus.i_debug_addr) >= BANK_DEPTH)))
      dbg_data_d = regs_q[bus.i_debug_addr];
  end

  always_ff @(posedge i_clock) begin
    if (state_q == ST_CLEAR) regs_q[cnt_q] <= '0;
    else if (wr_en_c)        regs_q[bus.i_write_reg] <= bus.i_write_data;
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q     <= ST_CLEAR;
      cnt_q       <= '0;
      rdata_q     <= '0;
      dbg_data_q  <= '0;
      dbg_valid_q <= 1'b0;
      busy_q      <= 1'b1;
    end else begin
      case (state_q)
        ST_CLEAR: begin
          rdata_q     <= '0;
          dbg_valid_q <= 1'b0;
          if (cnt_q == NB_ADDR'(BANK_DEPTH - 1)) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q + NB_ADDR'(1);
          end
        end
        ST_IDLE: begin
          if (bus.i_enable)        rdata_q    <= rdata_d;
          if (bus.i_debug_read_en) dbg_data_q <= dbg_data_d;
          dbg_valid_q <= bus.i_debug_read_en;
          if (bus.i_clear_req) begin
            state_q <= ST_CLEAR;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= ST_CLEAR;
          cnt_q   <= '0;
          busy_q  <= 1'b1;
        end
      endcase
    end
  end

  assign bus.o_read_data   = rdata_q;
  assign bus.o_debug_data  = dbg_data_q;
  assign bus.o_debug_valid = dbg_valid_q;
  assign bus.o_busy        = busy_q;

endmodule

// File: tb/tb_registers_bank_mp.sv
// Bench for registers_bank_mp: behavioural model checked every cycle plus directed
// literal expectations for the documented scenarios.
module tb_registers_bank_mp;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   total = 0;
  int   bad   = 0;
  bit   checks_on = 1'b0;

  always #5 clk = ~clk;

  registers_bank_mp_if #(.NB_DATA(32), .NB_ADDR(5), .NUM_READ(2)) bus ();

  registers_bank_mp dut (
    .i_clock   (clk),
    .i_reset_n (rst_n),
    .bus       (bus)
  );

  // Model: clear_left counts remaining sweep cycles; array is all-zero once it reaches 0.
  logic [31:0] m_regs [32];
  int          clear_left = 32;
  logic [63:0] exp_rd    = '0;
  logic [31:0] exp_dbg   = '0;
  logic        exp_valid = 1'b0;
  logic [31:0] mv;
  int          ma;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clear_left = 32;
      exp_rd     = '0;
      exp_dbg    = '0;
      exp_valid  = 1'b0;
    end else if (clear_left > 0) begin
      clear_left = clear_left - 1;
      exp_rd     = '0;
      exp_valid  = 1'b0;
      if (clear_left == 0) foreach (m_regs[i]) m_regs[i] = 32'h0;
    end else begin
      if (bus.i_enable) begin
        for (int p = 0; p < 2; p++) begin
          ma = (p == 0 && bus.i_jr_jalr) ? 31 : int'(bus.i_read_addr[p*5 +: 5]);
          if (ma == 0) mv = 32'h0;
          else if (bus.i_reg_write && int'(bus.i_write_reg) == ma) mv = bus.i_write_data;
          else mv = m_regs[ma];
          exp_rd[p*32 +: 32] = mv;
        end
      end
      exp_valid = bus.i_debug_read_en;
      if (bus.i_debug_read_en)
        exp_dbg = (bus.i_debug_addr == 5'd0) ? 32'h0 : m_regs[bus.i_debug_addr];
      if (bus.i_enable && bus.i_reg_write && bus.i_write_reg != 5'd0)
        m_regs[bus.i_write_reg] = bus.i_write_data;
      if (bus.i_clear_req) clear_left = 32;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (checks_on) begin
      check("cyc_rdata", bus.o_read_data, exp_rd);
      check("cyc_busy",  64'(bus.o_busy), 64'(clear_left > 0));
      check("cyc_valid", 64'(bus.o_debug_valid), 64'(exp_valid));
      check("cyc_dbg",   64'(bus.o_debug_data), 64'(exp_dbg));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.i_enable = 1'b1;  bus.i_reg_write = 1'b0; bus.i_write_reg = '0;
    bus.i_write_data = '0; bus.i_jr_jalr = 1'b0;  bus.i_read_addr = '0;
    bus.i_debug_read_en = 1'b0; bus.i_debug_addr = '0; bus.i_clear_req = 1'b0;
  endtask

  task automatic wr(input int a, input logic [31:0] d);
    bus.i_reg_write = 1'b1; bus.i_write_reg = 5'(a); bus.i_write_data = d;
    tick();
    bus.i_reg_write = 1'b0;
  endtask

  // Counts cycles o_busy stays high, starting with the current one.
  task automatic count_busy(output int n);
    n = 0;
    for (int k = 0; k < 100; k++) begin
      if (!bus.o_busy) break;
      n++;
      tick();
    end
  endtask

  int n;
  logic [31:0] held;

  initial begin
    idle_inputs();
    #2 rst_n = 1'b0;
    tick(); tick();
    checks_on = 1'b1;
    check("rst_busy",  64'(bus.o_busy), 64'h1);
    check("rst_rdata", bus.o_read_data, 64'h0);
    check("rst_valid", 64'(bus.o_debug_valid), 64'h0);
    rst_n = 1'b1;
    tick();
    count_busy(n);
    check("sweep_len", 64'(n + 1), 64'd32);

    bus.i_read_addr = {5'd5, 5'd0};
    tick();
    check("r5_p1", 64'(bus.o_read_data[63:32]), 64'h0);

    bus.i_read_addr = {5'd0, 5'd7};
    wr(7, 32'hDEADBEEF);
    check("bypass_r7", 64'(bus.o_read_data[31:0]), 64'hDEADBEEF);

    bus.i_read_addr = {5'd0, 5'd0};
    bus.i_debug_read_en = 1'b1; bus.i_debug_addr = 5'd0;
    wr(0, 32'h00001234);
    bus.i_debug_read_en = 1'b0;
    check("r0_ports", bus.o_read_data, 64'h0);
    check("r0_dbg",   64'(bus.o_debug_data), 64'h0);
    check("r0_valid", 64'(bus.o_debug_valid), 64'h1);
    tick();
    check("r0_pulse", 64'(bus.o_debug_valid), 64'h0);

    wr(3, 32'h00000033);
    wr(31, 32'h00000400);
    bus.i_jr_jalr = 1'b1; bus.i_read_addr = {5'd31, 5'd3};
    tick();
    bus.i_jr_jalr = 1'b0;
    check("jr_p0", 64'(bus.o_read_data[31:0]),  64'h400);
    check("jr_p1", 64'(bus.o_read_data[63:32]), 64'h400);

    for (int i = 1; i < 13; i++) begin
      bus.i_read_addr = {5'(i), 5'(i - 1)};
      wr(i, 32'h01010101 * 32'(i));
    end
    bus.i_read_addr = {5'd4, 5'd12};
    tick();
    check("sweep_p0", 64'(bus.o_read_data[31:0]),  64'h0C0C0C0C);
    check("sweep_p1", 64'(bus.o_read_data[63:32]), 64'h04040404);

    wr(2, 32'h00000011);
    bus.i_read_addr = {5'd0, 5'd2};
    tick();
    held = bus.o_read_data[31:0];
    check("pre_stall", 64'(held), 64'h11);
    bus.i_enable = 1'b0; bus.i_read_addr = {5'd0, 5'd7};
    bus.i_debug_read_en = 1'b1; bus.i_debug_addr = 5'd2;
    wr(2, 32'h00000055);
    bus.i_debug_read_en = 1'b0;
    check("stall_hold", 64'(bus.o_read_data[31:0]), 64'h11);
    check("stall_dbg",  64'(bus.o_debug_data), 64'h11);
    check("stall_vld",  64'(bus.o_debug_valid), 64'h1);
    tick();
    check("stall_pulse", 64'(bus.o_debug_valid), 64'h0);
    bus.i_enable = 1'b1; bus.i_read_addr = {5'd0, 5'd2};
    tick();
    check("stall_nowr", 64'(bus.o_read_data[31:0]), 64'h11);

    wr(9, 32'h000000A5);
    bus.i_clear_req = 1'b1;
    tick();
    bus.i_clear_req = 1'b0;
    bus.i_reg_write = 1'b1; bus.i_write_reg = 5'd9; bus.i_write_data = 32'hFF;
    count_busy(n);
    bus.i_reg_write = 1'b0;
    check("clr_len", 64'(n), 64'd32);
    bus.i_read_addr = {5'd2, 5'd9};
    tick();
    check("clr_r9", bus.o_read_data, 64'h0);

    wr(9, 32'h000000A5);
    bus.i_clear_req = 1'b1;
    tick();
    bus.i_clear_req = 1'b0;
    for (int k = 0; k < 10; k++) tick();
    rst_n = 1'b0;
    #1;
    check("midrst_busy",  64'(bus.o_busy), 64'h1);
    check("midrst_rdata", bus.o_read_data, 64'h0);
    tick();
    rst_n = 1'b1;
    tick();
    count_busy(n);
    check("restart_len", 64'(n + 1), 64'd32);
    tick();
    check("restart_r9", 64'(bus.o_read_data[31:0]), 64'h0);

    checks_on = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
